step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEP_W, default 4: microstep counter width.
REQ-002 SHALL have parameter OPC_W, default 8: opcode width.
REQ-003 SHALL have parameter FLAG_W, default 4: flag vector width.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port opcode  input  OPC_W: current instruction opcode.
REQ-007 SHALL have port flags  input  FLAG_W: ALU flags.
REQ-008 SHALL have port step_reset_n  input  1: active-low; restarts the microstep sequence.
REQ-009 SHALL have port step_ext  input  1: active-high; requests the extended opcode page.
REQ-010 SHALL have port ctrl_en_n  input  1: active-low; control-word drive and step counting enable.
REQ-011 SHALL have port step  output  STEP_W: current microstep.
REQ-012 SHALL have port ext_page  output  1: extended-page bit.
REQ-013 SHALL have port tc  output  1: counter terminal count.
REQ-014 SHALL have port rom_addr  output  STEP_W+FLAG_W+1+OPC_W: control ROM address.
REQ-015 SHALL have port cword_oe  output  1: control-word output enable.

Function
REQ-016 Step counter priority per edge SHALL be: rst, then step_reset_n==0 (load 0, regardless of the enables), then count (step+1) when step_ext==0 and ctrl_en_n==0, otherwise hold.
REQ-017 Step counting SHALL wrap from 2^STEP_W-1 to 0 (15 -> 0 by default).
REQ-018 tc SHALL be combinational: 1 when step==all-ones and ctrl_en_n==0, else 0.
REQ-019 Internal register ext_pending_n SHALL update each edge to (!step_reset_n) | (!step_ext & ext_pending_n).
REQ-020 ext_pending_n behaviour SHALL be: step_ext=1 with step_reset_n=1 clears it; step_reset_n=0 sets it; step_reset_n=0 has priority when both are asserted; otherwise it holds.
REQ-021 ext_page SHALL be registered each edge as the inverse of ext_pending_n before that edge, giving a one-cycle lag.
REQ-022 ext_page SHALL return to 0 one cycle after ext_pending_n is set, so a step reset ends the extended page.
REQ-023 step_ext SHALL not alter the step count except by disabling counting.
REQ-024 rom_addr SHALL be combinational {step, flags, ext_page, opcode}, step in the MSBs and opcode in the LSBs (17 bits by default).
REQ-025 cword_oe SHALL equal !ctrl_en_n, combinational.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set step=0, ext_pending_n=1 and ext_page=0, overriding all other inputs.
REQ-027 After reset: tc=0 and rom_addr={0, flags, 0, opcode}.
REQ-028 Reset asserted mid-sequence SHALL take effect on the next edge with no partial state retained.

Structure
REQ-029 Shared package step_seq_pkg SHALL hold the default widths and the ROM address field offsets (opcode LSB=0, ext_page=OPC_W, flags=OPC_W+1, step=OPC_W+FLAG_W+1).
REQ-030 The counter SHALL be a sub-module step_counter providing a 161-style synchronous counter: load value d, load_n, cep, cet, q, tc, with synchronous reset.
REQ-031 The ext_pending_n/ext_page logic SHALL live in the top module, with no latches and no combinational loops.

Verification
REQ-032 Counting: rst 1 cycle; step_reset_n=1, step_ext=0, ctrl_en_n=0 for 17 cycles -> step 0,1,...,15,0,1; tc=1 only while step=15.
REQ-033 Hold: at step=5, ctrl_en_n=1 for 3 cycles -> step stays 5, tc=0, cword_oe=0; ctrl_en_n=0 -> step becomes 6.
REQ-034 Step restart: at step=9, step_reset_n=0 for one edge with ctrl_en_n=1 -> step=0 next cycle.
REQ-035 Extended page, opcode=0x3C, flags=0xA: step_ext=1 one cycle -> ext_pending_n=0 and step holds. Next edge -> ext_page=1, rom_addr={step,4'hA,1,8'h3C}. Then step_reset_n=0 -> ext_page=0 one cycle later.
REQ-036 Collision: step_ext=1 and step_reset_n=0 together -> ext_pending_n=1, step=0, ext_page stays 0.
REQ-037 Reset mid-run: at step=12, ext_page=1, rst=1 one edge -> step=0, ext_page=0, tc=0.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared definitions for the microstep sequencer.
//   - Default widths for the step counter, opcode and flag vector.
//   - Control ROM address field offsets. The address is packed as
//     {step, flags, ext_page, opcode}, with the opcode in the LSBs.
package step_seq_pkg;

  localparam int DEF_STEP_W = 4;
  localparam int DEF_OPC_W  = 8;
  localparam int DEF_FLAG_W = 4;

  // The opcode always starts at bit 0.
  localparam int OPC_LSB = 0;

  // The extended-page bit sits directly above the opcode field.
  function automatic int ext_lsb(input int opc_w);
    return opc_w;
  endfunction

  // The flag field sits above the extended-page bit.
  function automatic int flags_lsb(input int opc_w);
    return opc_w + 1;
  endfunction

  // The microstep occupies the MSBs.
  function automatic int step_lsb(input int opc_w, input int flag_w);
    return opc_w + flag_w + 1;
  endfunction

  function automatic int rom_addr_w(input int step_w, input int opc_w, input int flag_w);
    return step_w + flag_w + 1 + opc_w;
  endfunction

  // Default field offsets and total width (17 bits).
  localparam int DEF_EXT_LSB    = ext_lsb(DEF_OPC_W);
  localparam int DEF_FLAGS_LSB  = flags_lsb(DEF_OPC_W);
  localparam int DEF_STEP_LSB   = step_lsb(DEF_OPC_W, DEF_FLAG_W);
  localparam int DEF_ROM_ADDR_W = rom_addr_w(DEF_STEP_W, DEF_OPC_W, DEF_FLAG_W);

endpackage

// File: rtl/step_counter.sv
// Synchronous binary counter modelled on the 74x161.
// Ports:
//   clk    - clock, all updates on the rising edge
//   rst    - synchronous active-high reset, clears q
//   d      - parallel load value
//   load_n - active-low synchronous load, overrides counting
//   cep    - count enable (parallel)
//   cet    - count enable (trickle); also gates tc
//   q      - counter value
//   tc     - terminal count: q is all-ones and cet is high
module step_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         load_n,
  input  logic         cep,
  input  logic         cet,
  output logic [W-1:0] q,
  output logic         tc
);

  logic [W-1:0] q_reg;

  // Load beats counting regardless of the enables. Counting wraps naturally
  // from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else if (!load_n) begin
      q_reg <= d;
    end else if (cep && cet) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q  = q_reg;
  assign tc = (&q_reg) & cet;

endmodule

// File: rtl/step_sequencer.sv
// Microstep sequencer: steps through microinstructions, tracks the extended
// opcode page and forms the control ROM address.
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   opcode       - current instruction opcode
//   flags        - ALU flags
//   step_reset_n - active-low, restarts the microstep sequence and ends the
//                  extended page
//   step_ext     - active-high, requests the extended opcode page (also stalls
//                  the step counter for that cycle)
//   ctrl_en_n    - active-low, enables control-word drive and step counting
//   step         - current microstep
//   ext_page     - extended-page bit
//   tc           - step counter terminal count
//   rom_addr     - control ROM address {step, flags, ext_page, opcode}
//   cword_oe     - control-word output enable
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int FLAG_W = DEF_FLAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OPC_W-1:0]              opcode,
  input  logic [FLAG_W-1:0]             flags,
  input  logic                          step_reset_n,
  input  logic                          step_ext,
  input  logic                          ctrl_en_n,
  output logic [STEP_W-1:0]             step,
  output logic                          ext_page,
  output logic                          tc,
  output logic [STEP_W+FLAG_W+OPC_W:0]  rom_addr,
  output logic                          cword_oe
);

  localparam int EXT_LSB   = ext_lsb(OPC_W);
  localparam int FLAGS_LSB = flags_lsb(OPC_W);
  localparam int STEP_LSB  = step_lsb(OPC_W, FLAG_W);

  logic ext_pending_n_reg;
  logic ext_pending_n_next;
  logic ext_page_reg;

  // Step counter: step reset loads zero, step_ext stalls counting through the
  // parallel enable, ctrl_en_n gates both counting and tc through the
  // trickle enable.
  step_counter #(
    .W(STEP_W)
  ) u_step_counter (
    .clk    (clk),
    .rst    (rst),
    .d      ('0),
    .load_n (step_reset_n),
    .cep    (!step_ext),
    .cet    (!ctrl_en_n),
    .q      (step),
    .tc     (tc)
  );

  // Pending flag is active-low: a step_ext request clears it, a step reset
  // sets it, and the step reset wins when both arrive together.
  always_comb begin
    ext_pending_n_next = (!step_reset_n) | (!step_ext & ext_pending_n_reg);
  end

  // ext_page follows the pending flag one cycle later, so a page request
  // becomes visible on the second edge and a step reset ends it likewise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pending_n_reg <= 1'b1;
      ext_page_reg      <= 1'b0;
    end else begin
      ext_pending_n_reg <= ext_pending_n_next;
      ext_page_reg      <= !ext_pending_n_reg;
    end
  end

  assign ext_page = ext_page_reg;
  assign cword_oe = !ctrl_en_n;

  // ROM address assembly using the shared field offsets.
  genvar gi;
  generate
    for (gi = 0; gi < OPC_W; gi++) begin : g_opc_field
      assign rom_addr[OPC_LSB + gi] = opcode[gi];
    end
    for (gi = 0; gi < FLAG_W; gi++) begin : g_flag_field
      assign rom_addr[FLAGS_LSB + gi] = flags[gi];
    end
    for (gi = 0; gi < STEP_W; gi++) begin : g_step_field
      assign rom_addr[STEP_LSB + gi] = step[gi];
    end
  endgenerate

  assign rom_addr[EXT_LSB] = ext_page_reg;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios followed by
// randomized traffic, all outputs compared against a behavioural model.
module tb_step_sequencer;

  localparam int STEP_W = 4;
  localparam int OPC_W  = 8;
  localparam int FLAG_W = 4;
  localparam int AW     = STEP_W + FLAG_W + 1 + OPC_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [OPC_W-1:0]  opcode = '0;
  logic [FLAG_W-1:0] flags = '0;
  logic              step_reset_n = 1'b1;
  logic              step_ext = 1'b0;
  logic              ctrl_en_n = 1'b1;
  logic [STEP_W-1:0] step;
  logic              ext_page;
  logic              tc;
  logic [AW-1:0]     rom_addr;
  logic              cword_oe;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_step = 0;
  bit m_pending = 0;  // extended page requested (active-high view)
  bit m_page = 0;

  step_sequencer #(
    .STEP_W(STEP_W),
    .OPC_W (OPC_W),
    .FLAG_W(FLAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .flags       (flags),
    .step_reset_n(step_reset_n),
    .step_ext    (step_ext),
    .ctrl_en_n   (ctrl_en_n),
    .step        (step),
    .ext_page    (ext_page),
    .tc          (tc),
    .rom_addr    (rom_addr),
    .cword_oe    (cword_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit page_next;
    page_next = m_pending;
    if (rst) begin
      m_step = 0; m_pending = 0; m_page = 0;
    end else begin
      if (!step_reset_n) m_step = 0;
      else if (!step_ext && !ctrl_en_n) m_step = (m_step + 1) % (1 << STEP_W);
      if (!step_reset_n) m_pending = 0;
      else if (step_ext) m_pending = 1;
      m_page = page_next;
    end
  endtask

  task automatic check_all(input string tag);
    int exp_addr;
    int exp_tc;
    exp_tc = (m_step == (1 << STEP_W) - 1 && !ctrl_en_n) ? 1 : 0;
    exp_addr = m_step * (1 << (FLAG_W + 1 + OPC_W)) + int'(flags) * (1 << (OPC_W + 1))
             + int'(m_page) * (1 << OPC_W) + int'(opcode);
    chk({tag, ".step"}, 32'(step), 32'(m_step));
    chk({tag, ".ext_page"}, 32'(ext_page), 32'(m_page));
    chk({tag, ".tc"}, 32'(tc), 32'(exp_tc));
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(exp_addr));
    chk({tag, ".cword_oe"}, 32'(cword_oe), ctrl_en_n ? 32'd0 : 32'd1);
  endtask

  task automatic drive(input bit r, input bit srn, input bit ext, input bit en_n);
    rst = r; step_reset_n = srn; step_ext = ext; ctrl_en_n = en_n;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    $display("cyc %-12s rst=%0b srn=%0b ext=%0b en_n=%0b op=%02h fl=%0h -> step=%0d page=%0b tc=%0b addr=%05h",
             tag, rst, step_reset_n, step_ext, ctrl_en_n, opcode, flags, step, ext_page, tc, rom_addr);
  endtask

  // Count until the model reaches a target step, bounded by one full wrap.
  task automatic count_to(input int target, input string tag);
    int n;
    n = 0;
    drive(0, 1, 0, 0);
    while (m_step != target && n < (1 << STEP_W) + 1) begin
      cycle(tag);
      n++;
    end
    chk({tag, ".reached"}, 32'(step), 32'(target));
  endtask

  initial begin
    opcode = 8'h11; flags = 4'h2;

    // Reset state
    drive(1, 1, 0, 0);
    cycle("reset");
    drive(0, 1, 0, 1);
    #1;
    chk("reset.tc_idle", 32'(tc), 32'd0);
    chk("reset.addr", 32'(rom_addr), {15'd0, 4'd0, 4'h2, 1'b0, 8'h11});

    // Counting with wrap: 17 edges from 0
    drive(0, 1, 0, 0);
    for (int i = 0; i < 17; i++) cycle("count");
    chk("count.wrap_step", 32'(step), 32'd1);

    // Hold at 5
    count_to(5, "to5");
    drive(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle("hold");
    chk("hold.step5", 32'(step), 32'd5);
    chk("hold.oe_off", 32'(cword_oe), 32'd0);
    drive(0, 1, 0, 0);
    cycle("resume");
    chk("resume.step6", 32'(step), 32'd6);

    // Step restart at 9 with counting disabled
    count_to(9, "to9");
    drive(0, 0, 0, 1);
    cycle("restart");
    chk("restart.step0", 32'(step), 32'd0);

    // Extended page
    opcode = 8'h3C; flags = 4'hA;
    drive(0, 1, 1, 0);
    cycle("ext_req");
    chk("ext_req.step_held", 32'(step), 32'd0);
    drive(0, 1, 0, 1);
    cycle("ext_on");
    chk("ext_on.page", 32'(ext_page), 32'd1);
    chk("ext_on.addr", 32'(rom_addr), {15'd0, 4'd0, 4'hA, 1'b1, 8'h3C});
    drive(0, 0, 0, 1);
    cycle("ext_end0");
    drive(0, 1, 0, 1);
    cycle("ext_end1");
    chk("ext_end.page", 32'(ext_page), 32'd0);

    // Collision: step reset wins over the page request
    count_to(3, "to3");
    drive(0, 0, 1, 0);
    cycle("collide");
    drive(0, 1, 0, 1);
    cycle("collide2");
    chk("collide.page", 32'(ext_page), 32'd0);
    chk("collide.step", 32'(step), 32'd0);

    // Reset mid-run with ext_page active at step 12
    drive(0, 1, 1, 1);
    cycle("pg_req");
    drive(0, 1, 0, 1);
    cycle("pg_on");
    count_to(12, "to12");
    chk("mid.page_on", 32'(ext_page), 32'd1);
    drive(1, 1, 0, 0);
    cycle("midrst");
    chk("midrst.step", 32'(step), 32'd0);
    chk("midrst.page", 32'(ext_page), 32'd0);
    drive(0, 1, 0, 1);
    cycle("post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      opcode = 8'($urandom);
      flags  = 4'($urandom);
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
